// File: rtl/y86_regfile_wr_pkg.sv
// Shared Y86-64 definitions: register IDs, data width, icode/ifun values.
// Imported by decode, write-back and the register file.
package y86_regfile_wr_pkg;

  localparam int DW   = 64;
  localparam int NREG = 15;

  typedef logic [3:0] reg_id_t;
  typedef logic [DW-1:0] word_t;

  localparam reg_id_t RRAX  = 4'h0;
  localparam reg_id_t RRCX  = 4'h1;
  localparam reg_id_t RRDX  = 4'h2;
  localparam reg_id_t RRBX  = 4'h3;
  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RRBP  = 4'h5;
  localparam reg_id_t RRSI  = 4'h6;
  localparam reg_id_t RRDI  = 4'h7;
  localparam reg_id_t RR8   = 4'h8;
  localparam reg_id_t RR9   = 4'h9;
  localparam reg_id_t RR10  = 4'hA;
  localparam reg_id_t RR11  = 4'hB;
  localparam reg_id_t RR12  = 4'hC;
  localparam reg_id_t RR13  = 4'hD;
  localparam reg_id_t RR14  = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] F_NONE = 4'h0;
  localparam logic [3:0] A_ADD  = 4'h0;
  localparam logic [3:0] A_SUB  = 4'h1;
  localparam logic [3:0] A_AND  = 4'h2;
  localparam logic [3:0] A_XOR  = 4'h3;

  function automatic logic id_ok(reg_id_t id);
    return (id != RNONE) && (id < reg_id_t'(NREG));
  endfunction

endpackage

// File: rtl/y86_regfile_wr_arb.sv
// Write-port arbiter: qualifies E/M writes, M wins a same-ID collision.
// n_commit counts physical register updates this edge (0..2).
module y86_rf_wport_arb
  import y86_regfile_wr_pkg::*;
(
  input  logic [3:0] dstE,
  input  logic [3:0] dstM,
  input  logic       wr_en,
  output logic       we_E,
  output logic       we_M,
  output logic [1:0] n_commit
);

  logic ok_e;
  logic ok_m;
  logic clash;

  always_comb begin
    ok_e     = wr_en && id_ok(dstE);
    ok_m     = wr_en && id_ok(dstM);
    clash    = ok_e && ok_m && (dstE == dstM);
    we_E     = ok_e && !clash;
    we_M     = ok_m;
    n_commit = {1'b0, we_E} + {1'b0, we_M};
  end

endmodule

// File: rtl/y86_regfile_wr.sv
// Y86-64 SEQ register file: two comb read ports, two clocked write ports,
// saturating count of committed writes.
module y86_regfile_wr
  import y86_regfile_wr_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    srcA,
  input  logic [3:0]    srcB,
  output logic [DW-1:0] valA,
  output logic [DW-1:0] valB,
  input  logic [3:0]    dstE,
  input  logic [DW-1:0] valE,
  input  logic [3:0]    dstM,
  input  logic [DW-1:0] valM,
  input  logic          wr_en,
  output logic [7:0]    wr_cnt
);

  logic [DW-1:0] rf_q [0:NREG-1];
  logic [DW-1:0] rf_d [0:NREG-1];
  logic [7:0]    cnt_q;
  logic [7:0]    cnt_d;
  logic [8:0]    cnt_sum;
  logic          we_E;
  logic          we_M;
  logic [1:0]    n_commit;

  y86_rf_wport_arb u_arb (
    .dstE     (dstE),
    .dstM     (dstM),
    .wr_en    (wr_en),
    .we_E     (we_E),
    .we_M     (we_M),
    .n_commit (n_commit)
  );

  always_comb begin
    rf_d = rf_q;
    if (we_E) rf_d[dstE] = valE;
    if (we_M) rf_d[dstM] = valM;
  end

  always_comb begin
    cnt_sum = {1'b0, cnt_q} + {7'd0, n_commit};
    cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      rf_q  <= rf_d;
      cnt_q <= cnt_d;
    end
  end

  // No bypass: reads see only committed state.
  always_comb begin
    valA = id_ok(srcA) ? rf_q[srcA] : '0;
    valB = id_ok(srcB) ? rf_q[srcB] : '0;
  end

  assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_y86_regfile_wr.sv
// Directed bench with expected-value queue and a decoupled checking monitor.
// Inputs change 1ns after rising edges; outputs sampled mid-cycle.
module tb_y86_regfile_wr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB, valE, valM;
  logic        wr_en;
  logic [7:0]  wr_cnt;

  y86_regfile_wr dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .srcA   (srcA),
    .srcB   (srcB),
    .valA   (valA),
    .valB   (valB),
    .dstE   (dstE),
    .valE   (valE),
    .dstM   (dstM),
    .valM   (valM),
    .wr_en  (wr_en),
    .wr_cnt (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  event ev_chk;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: on each sample strobe, compare every queued expectation.
  initial begin
    forever begin
      @(ev_chk);
      while (q.size() > 0) begin
        exp_t e;
        logic [63:0] act;
        e = q.pop_front();
        case (e.sel)
          0:       act = valA;
          1:       act = valB;
          default: act = {56'd0, wr_cnt};
        endcase
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_a(input logic [63:0] v, input string n);
    exp_t e;
    e.sel = 0; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic expect_b(input logic [63:0] v, input string n);
    exp_t e;
    e.sel = 1; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic expect_c(input logic [7:0] v, input string n);
    exp_t e;
    e.sel = 2; e.exp = {56'd0, v}; e.name = n;
    q.push_back(e);
  endtask

  task automatic sample();
    #1;
    -> ev_chk;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    dstE  = 4'hF;
    dstM  = 4'hF;
    valE  = '0;
    valM  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    srcA  = 4'hF;
    srcB  = 4'hF;
    idle();

    // Dirty the file first so reset visibly clears it.
    step();
    dstE = 4'h1; valE = 64'hDEAD; wr_en = 1'b1;
    step();
    idle();
    srcA = 4'h1;
    #2;
    rst_n = 1'b0;
    expect_a(64'h0, "async_rst_valA");
    expect_b(64'h0, "async_rst_valB");
    expect_c(8'h00, "async_rst_cnt");
    sample();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      srcA = 4'(i);
      srcB = 4'(i);
      expect_a(64'h0, $sformatf("post_rst_A%0d", i));
      expect_b(64'h0, $sformatf("post_rst_B%0d", i));
      sample();
    end

    // Single write, no bypass before the edge.
    srcA = 4'h0;
    dstE = 4'h0; valE = 64'h12345678_90ABCDEF; wr_en = 1'b1;
    expect_a(64'h0, "no_bypass");
    sample();
    step();
    idle();
    expect_a(64'h12345678_90ABCDEF, "single_wr");
    expect_c(8'd1, "single_cnt");
    sample();

    // Dual write.
    dstE = 4'h3; valE = 64'hFEDCBA09_87654321;
    dstM = 4'h7; valM = 64'hA5A5A5A5_5A5A5A5A;
    wr_en = 1'b1;
    step();
    idle();
    srcA = 4'h3; srcB = 4'h7;
    expect_a(64'hFEDCBA09_87654321, "dual_E");
    expect_b(64'hA5A5A5A5_5A5A5A5A, "dual_M");
    expect_c(8'd3, "dual_cnt");
    sample();

    // Collision: M wins, counts once.
    dstE = 4'h4; valE = 64'h1;
    dstM = 4'h4; valM = 64'h2;
    wr_en = 1'b1;
    step();
    idle();
    srcA = 4'h4;
    expect_a(64'h2, "collide_val");
    expect_c(8'd4, "collide_cnt");
    sample();

    // wr_en low suppresses.
    dstE = 4'h5; valE = 64'h55;
    dstM = 4'h6; valM = 64'h66;
    wr_en = 1'b0;
    step();
    idle();
    srcA = 4'h5; srcB = 4'h6;
    expect_a(64'h0, "wren0_E");
    expect_b(64'h0, "wren0_M");
    expect_c(8'd4, "wren0_cnt");
    sample();

    // RNONE destinations suppress.
    dstE = 4'hF; valE = 64'h77;
    dstM = 4'hF; valM = 64'h88;
    wr_en = 1'b1;
    step();
    idle();
    srcA = 4'hF; srcB = 4'h0;
    expect_a(64'h0, "rnone_read");
    expect_b(64'h12345678_90ABCDEF, "reg0_kept");
    expect_c(8'd4, "rnone_cnt");
    sample();

    // Highest valid ID on port M only.
    dstM = 4'hE; valM = 64'hCAFE_F00D; wr_en = 1'b1;
    step();
    idle();
    srcA = 4'hE;
    expect_a(64'hCAFE_F00D, "r14_wr");
    expect_c(8'd5, "r14_cnt");
    sample();

    // Saturation: 5 + 2*200 clamps at 255.
    for (int i = 0; i < 200; i++) begin
      dstE = 4'h1; valE = 64'(i);
      dstM = 4'h2; valM = 64'(i + 1000);
      wr_en = 1'b1;
      step();
    end
    idle();
    srcA = 4'h1; srcB = 4'h2;
    expect_a(64'd199, "sat_reg1");
    expect_b(64'd1199, "sat_reg2");
    expect_c(8'hFF, "sat_cnt");
    sample();
    dstE = 4'h9; valE = 64'h9; wr_en = 1'b1;
    step();
    idle();
    expect_c(8'hFF, "sat_hold");
    sample();

    // Reset inside a write cycle loses the pending write.
    srcA = 4'h8; srcB = 4'h0;
    dstE = 4'h8; valE = 64'hBEEF; wr_en = 1'b1;
    #2;
    rst_n = 1'b0;
    expect_b(64'h0, "midrst_reg0");
    expect_c(8'h00, "midrst_cnt");
    sample();
    step();
    idle();
    rst_n = 1'b1;
    expect_a(64'h0, "midrst_lost");
    expect_c(8'h00, "midrst_cnt2");
    sample();

    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
